// File: rtl/i2c_types_pkg.sv
// Shared types for the I2C slave byte engine: FSM state encoding and bus constants.
package i2c_types_pkg;

    localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_TX_BYTE,
        S_TX_ACKCHK,
        S_IGNORE
    } i2c_slv_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus agreement filter for one raw bus line; emits the filtered level and
// single-cycle rise/fall strobes aligned with the filtered level change.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   sync_d;
    logic                   smp;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d, fall_q, fall_d;

    assign sync_d = {sync_q, line_i};
    assign smp    = sync_q[SYNC_STAGES-1];

    // A new level is accepted once FILTER_LEN consecutive synced samples disagree with the current one.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (smp != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = smp;
                rise_d = smp;
                fall_d = ~smp;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d[SYNC_STAGES-1:0];
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign line_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave front-end: START/STOP detection, address match, write-byte receive, read-byte transmit.
// Define I2C_SLV_GENERAL_CALL_EN to ACK writes to the general-call address 7'h00.
module i2c_slave_byte_engine
    import i2c_types_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    input  logic [I2C_ADDR_WIDTH-1:0] slave_addr_i,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      start_o,
    output logic                      restart_o,
    output logic                      stop_o,
    output logic                      rw_o,
    output logic                      busy_o,
    output logic                      nack_o,
    output logic                      tx_underrun_o
);
    localparam int DW    = I2C_DATA_WIDTH;
    localparam int CNT_W = $clog2(DW + 1);

    logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(scl_i),
        .line_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(sda_i),
        .line_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_slv_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    shift_q, shift_d, rx_data_q, rx_data_d, tx_byte;
    logic             sda_q, sda_d, rw_q, rw_d;
    logic             rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
    logic             start_q, start_d, restart_q, restart_d, stop_q, stop_d;
    logic             nack_q, nack_d, underrun_q, underrun_d;
    logic             start_det, stop_det, own_hit, gc_hit;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign own_hit   = (shift_q[DW-1:1] == slave_addr_i);
`ifdef I2C_SLV_GENERAL_CALL_EN
    assign gc_hit    = (shift_q[DW-1:1] == I2C_GENERAL_CALL_ADDR) & ~shift_q[0];
`else
    assign gc_hit    = 1'b0;
`endif
    assign tx_byte   = tx_valid_i ? tx_data_i : '1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sda_d      = sda_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        tx_ready_d = 1'b0;
        start_d    = 1'b0;
        restart_d  = 1'b0;
        stop_d     = 1'b0;
        nack_d     = 1'b0;
        underrun_d = 1'b0;
        if (start_det) begin
            state_d   = S_ADDR;
            cnt_d     = '0;
            sda_d     = 1'b1;
            start_d   = (state_q == S_IDLE);
            restart_d = (state_q != S_IDLE);
        end else if (stop_det) begin
            state_d = S_IDLE;
            sda_d   = 1'b1;
            stop_d  = 1'b1;
        end else begin
            case (state_q)
                S_ADDR, S_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[DW-2:0], sda_f};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (scl_fall && cnt_q == CNT_W'(DW)) begin
                        if (state_q == S_RX_BYTE) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_d      = 1'b0;
                            state_d    = S_RX_ACK;
                        end else if (own_hit || gc_hit) begin
                            sda_d   = 1'b0;
                            state_d = S_ADDR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    rw_d  = shift_q[0];
                    cnt_d = '0;
                    if (shift_q[0]) begin
                        shift_d    = tx_byte;
                        sda_d      = tx_byte[DW-1];
                        tx_ready_d = tx_valid_i;
                        underrun_d = ~tx_valid_i;
                        state_d    = S_TX_BYTE;
                    end else begin
                        sda_d   = 1'b1;
                        state_d = S_RX_BYTE;
                    end
                end
                S_RX_ACK: if (scl_fall) begin
                    sda_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RX_BYTE;
                end
                S_TX_BYTE: if (scl_fall) begin
                    if (cnt_q == CNT_W'(DW - 1)) begin
                        sda_d   = 1'b1;
                        state_d = S_TX_ACKCHK;
                    end else begin
                        shift_d = {shift_q[DW-2:0], 1'b1};
                        sda_d   = shift_q[DW-2];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                // Reaching an SCL fall here means the ACK rise already passed without a NACK.
                S_TX_ACKCHK: begin
                    if (scl_rise && sda_f) begin
                        nack_d  = 1'b1;
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        shift_d    = tx_byte;
                        sda_d      = tx_byte[DW-1];
                        tx_ready_d = tx_valid_i;
                        underrun_d = ~tx_valid_i;
                        cnt_d      = '0;
                        state_d    = S_TX_BYTE;
                    end
                end
                default: sda_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            sda_q      <= 1'b1;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            start_q    <= 1'b0;
            restart_q  <= 1'b0;
            stop_q     <= 1'b0;
            nack_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sda_q      <= sda_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            start_q    <= start_d;
            restart_q  <= restart_d;
            stop_q     <= stop_d;
            nack_q     <= nack_d;
            underrun_q <= underrun_d;
        end
    end

    assign sda_o         = sda_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = tx_ready_q;
    assign start_o       = start_q;
    assign restart_o     = restart_q;
    assign stop_o        = stop_q;
    assign rw_o          = rw_q;
    assign busy_o        = (state_q != S_IDLE);
    assign nack_o        = nack_q;
    assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Directed bench: bit-banged I2C master on a wired-AND bus against the slave byte engine.
module tb_i2c_slave_byte_engine;
    localparam int Q = 10;  // clk cycles per SCL quarter period
`ifdef I2C_SLV_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk_i = 1'b0, rst_i = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_i, sda_i, sda_o;
    logic [6:0] slave_addr_i = 7'h22;
    logic [7:0] rx_data_o, tx_data_i;
    logic       rx_valid_o, tx_valid_i, tx_ready_o, start_o, restart_o, stop_o;
    logic       rw_o, busy_o, nack_o, tx_underrun_o;

    assign scl_i = scl_m;
    assign sda_i = sda_m & sda_o;

    i2c_slave_byte_engine dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda_o),
        .slave_addr_i(slave_addr_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .start_o(start_o), .restart_o(restart_o), .stop_o(stop_o), .rw_o(rw_o),
        .busy_o(busy_o), .nack_o(nack_o), .tx_underrun_o(tx_underrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Cumulative event counters; tests compare deltas against snapshots.
    int n_rx = 0, n_txr = 0, n_start = 0, n_restart = 0, n_stop = 0, n_nack = 0, n_und = 0, n_low = 0;
    logic [7:0] rx_log [32];
    always @(negedge clk_i) begin
        if (rx_valid_o === 1'b1) begin rx_log[n_rx % 32] <= rx_data_o; n_rx <= n_rx + 1; end
        if (tx_ready_o === 1'b1)    n_txr     <= n_txr + 1;
        if (start_o === 1'b1)       n_start   <= n_start + 1;
        if (restart_o === 1'b1)     n_restart <= n_restart + 1;
        if (stop_o === 1'b1)        n_stop    <= n_stop + 1;
        if (nack_o === 1'b1)        n_nack    <= n_nack + 1;
        if (tx_underrun_o === 1'b1) n_und     <= n_und + 1;
        if (sda_o === 1'b0)         n_low     <= n_low + 1;
    end

    logic [7:0] tx_mem [4];
    int tx_base = 0, tx_len = 0, tx_idx;
    always_comb begin
        tx_idx     = n_txr - tx_base;
        tx_data_i  = tx_mem[tx_idx[1:0]];
        tx_valid_i = (tx_idx < tx_len);
    end

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int s_rx, s_txr, s_start, s_restart, s_stop, s_nack, s_und, s_low;
    task automatic snap();
        s_rx = n_rx; s_txr = n_txr; s_start = n_start; s_restart = n_restart;
        s_stop = n_stop; s_nack = n_nack; s_und = n_und; s_low = n_low;
    endtask

    task automatic wq(input int n = 1);
        repeat (n * Q) @(posedge clk_i);
        #1;
    endtask
    task automatic m_start();
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(2); sda_m = 1'b0; wq(2); scl_m = 1'b0; wq();
    endtask
    task automatic m_stop();
        sda_m = 1'b0; wq(); scl_m = 1'b1; wq(2); sda_m = 1'b1; wq(2);
    endtask
    task automatic m_wbit(input logic b);
        sda_m = b; wq(); scl_m = 1'b1; wq(2); scl_m = 1'b0; wq();
    endtask
    task automatic m_rbit(output logic b);
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_i; wq(); scl_m = 1'b0; wq();
    endtask
    task automatic m_wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
        m_rbit(ack);
    endtask
    task automatic m_rbyte(output logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) m_rbit(d[i]);
        m_wbit(mack);
    endtask

    logic       a0, a1, a2, b7;
    logic [7:0] r0, r1;

    initial begin
        // 1. reset
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_sda", sda_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rxdata", rx_data_o, 8'h00);
        chk("rst_rw", rw_o, 1'b0);
        wq(2);
        chk("rst_nostart", n_start, 0);

        // 2. write 0xA5, 0x3C to 0x22
        snap();
        m_start();
        m_wbyte(8'h44, a0); m_wbyte(8'hA5, a1); m_wbyte(8'h3C, a2);
        m_stop(); wq();
        chk("wr_ack_addr", a0, 1'b0);
        chk("wr_ack_d0", a1, 1'b0);
        chk("wr_ack_d1", a2, 1'b0);
        chk("wr_rx_cnt", n_rx - s_rx, 2);
        chk("wr_rx0", rx_log[s_rx % 32], 8'hA5);
        chk("wr_rx1", rx_log[(s_rx + 1) % 32], 8'h3C);
        chk("wr_stop_cnt", n_stop - s_stop, 1);
        chk("wr_start_cnt", n_start - s_start, 1);
        chk("wr_rw", rw_o, 1'b0);
        chk("wr_busy_end", busy_o, 1'b0);

        // 3. write to foreign address 0x23
        snap();
        m_start();
        m_wbyte(8'h46, a0);
        m_wbyte(8'h55, a1);
        chk("ign_busy", busy_o, 1'b1);
        m_stop(); wq();
        chk("ign_ack_addr", a0, 1'b1);
        chk("ign_ack_d", a1, 1'b1);
        chk("ign_sda_low", n_low - s_low, 0);
        chk("ign_rx_cnt", n_rx - s_rx, 0);
        chk("ign_busy_end", busy_o, 1'b0);

        // 4. read 0x81, 0x7E with ACK then NACK
        tx_mem[0] = 8'h81; tx_mem[1] = 8'h7E; tx_base = n_txr; tx_len = 2;
        snap();
        m_start();
        m_wbyte(8'h45, a0);
        m_rbyte(r0, 1'b0);
        m_rbyte(r1, 1'b1);
        chk("rd_rw", rw_o, 1'b1);
        m_stop(); wq();
        chk("rd_ack_addr", a0, 1'b0);
        chk("rd_byte0", r0, 8'h81);
        chk("rd_byte1", r1, 8'h7E);
        chk("rd_txready", n_txr - s_txr, 2);
        chk("rd_nack", n_nack - s_nack, 1);
        chk("rd_underrun", n_und - s_und, 0);

        // 5. repeated START after 4 bits of a write byte, then read
        tx_mem[0] = 8'h5A; tx_base = n_txr; tx_len = 1;
        snap();
        m_start();
        m_wbyte(8'h44, a0);
        m_wbit(1'b1); m_wbit(1'b0); m_wbit(1'b1); m_wbit(1'b0);
        m_start();
        m_wbyte(8'h45, a1);
        m_rbit(b7);
        for (int i = 6; i >= 0; i--) m_rbit(r0[i]);
        r0[7] = b7;
        m_wbit(1'b1);
        m_stop(); wq();
        chk("rs_ack_addr", a1, 1'b0);
        chk("rs_restart", n_restart - s_restart, 1);
        chk("rs_start", n_start - s_start, 1);
        chk("rs_rx_cnt", n_rx - s_rx, 0);
        chk("rs_bit7", b7, 1'b0);
        chk("rs_byte", r0, 8'h5A);

        // underrun: read with nothing queued
        tx_base = n_txr; tx_len = 0;
        snap();
        m_start();
        m_wbyte(8'h45, a0);
        m_rbyte(r0, 1'b1);
        m_stop(); wq();
        chk("ur_byte", r0, 8'hFF);
        chk("ur_pulse", n_und - s_und, 1);
        chk("ur_txready", n_txr - s_txr, 0);

        // 6. 2-cycle SDA glitch while SCL high, then general call write
        snap();
        @(posedge clk_i); #1 sda_m = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 sda_m = 1'b1;
        wq(2);
        chk("gl_nostart", n_start - s_start, 0);
        chk("gl_busy", busy_o, 1'b0);
        snap();
        m_start();
        m_wbyte(8'h00, a0);
        m_wbyte(8'h99, a1);
        m_stop(); wq();
        chk("gc_ack_addr", a0, GC ? 1'b0 : 1'b1);
        chk("gc_rx_cnt", n_rx - s_rx, GC ? 1 : 0);
        if (GC) chk("gc_rx_data", rx_log[s_rx % 32], 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
